// File: rtl/alu_seq.sv
// alu_seq: registered sequential ALU, one operation per START/DONE handshake.
// Logic, move, add and sub finish in one cycle. Shifts and rotates step one bit per cycle.
//
// Optional feature macro: ALU_SEQ_ROTATE_EN
//   defined   -> opcodes 9 (ROR) and 10 (ROL) rotate through carry on {SC_IN, A}
//   undefined -> opcodes 9 and 10 decode as illegal, and no rotate logic is built
//
// Parameters:
//   W   datapath width (>= 4)
//   CW  shift-amount field width, $clog2(W)+1 (derived, not overridable)
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_start    request, sampled only while idle
//   i_op       4-bit opcode, captured with i_start
//   i_inputa   operand A, captured with i_start
//   i_inputb   operand B or shift amount (low CW bits), captured with i_start
//   i_sc_in    carry in, captured with i_start
//   o_busy     high whenever the unit is not idle
//   o_done     one-cycle pulse; results are valid in this cycle
//   o_out      registered result, held until the next o_done
//   o_sc_out   registered carry, or the last bit shifted out
//   o_zero     registered (o_out == 0)
//   o_illegal  high together with o_done for an unsupported opcode
module alu_seq #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W) + 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_inputa,
    input  logic [W-1:0] i_inputb,
    input  logic         i_sc_in,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_out,
    output logic         o_sc_out,
    output logic         o_zero,
    output logic         o_illegal
);

    localparam logic [3:0] OP_MOV  = 4'd0;
    localparam logic [3:0] OP_MOVR = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
`ifdef ALU_SEQ_ROTATE_EN
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
`endif

    // Logical shifts saturate here: past W+1 steps nothing changes any more.
    localparam logic [CW-1:0] SH_MAX = CW'(W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_op;
    logic [W-1:0]    r_a;
    logic            r_c;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    r_out;
    logic            r_sc;
    logic            r_zero;
    logic            r_illegal;

    logic [CW-1:0]   w_amt;
    logic [CW-1:0]   w_n;
    logic            w_shift_op;
    logic            w_go_shift;
    logic [W-1:0]    w_res;
    logic            w_c;
    logic            w_ill;

    logic [W-1:0]    w_step_a;
    logic            w_step_c;

    logic            w_accept;
    logic            w_last;

    // ------------------------------------------------------------------
    // Decode of the incoming request. Single-cycle results are produced
    // here directly from the inputs and loaded on the acceptance edge.
    // ------------------------------------------------------------------
    assign w_amt = i_inputb[CW-1:0];

    always_comb begin
        w_shift_op = 1'b0;
        w_n        = '0;
        w_res      = '0;
        w_c        = 1'b0;
        w_ill      = 1'b0;
        case (i_op)
            OP_MOV: begin
                w_res = i_inputa;
            end
            OP_MOVR: begin
                w_res = i_inputb;
            end
            OP_XOR: begin
                w_res = i_inputa ^ i_inputb;
            end
            OP_OR: begin
                w_res = i_inputa | i_inputb;
            end
            OP_AND: begin
                w_res = i_inputa & i_inputb;
            end
            OP_ADD: begin
                {w_c, w_res} = {1'b0, i_inputa}
                             + {1'b0, i_inputb}
                             + {{W{1'b0}}, i_sc_in};
            end
            OP_SUB: begin
                // Carry out set means no borrow.
                {w_c, w_res} = {1'b0, i_inputa}
                             + {1'b0, ~i_inputb}
                             + {{W{1'b0}}, 1'b1};
            end
            OP_SHR, OP_SHL: begin
                w_shift_op = 1'b1;
                w_n        = (w_amt > SH_MAX) ? SH_MAX : w_amt;
                w_res      = i_inputa;
                w_c        = 1'b0;
            end
`ifdef ALU_SEQ_ROTATE_EN
            OP_ROR, OP_ROL: begin
                // Zero-step rotate leaves {SC_IN, A} untouched.
                w_shift_op = 1'b1;
                w_n        = w_amt;
                w_res      = i_inputa;
                w_c        = i_sc_in;
            end
`endif
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    assign w_go_shift = w_shift_op && (w_n != '0);

    // ------------------------------------------------------------------
    // One single-bit step of the captured shift/rotate.
    // ------------------------------------------------------------------
    always_comb begin
        w_step_a = r_a;
        w_step_c = r_c;
        case (r_op)
            OP_SHR: begin
                w_step_a = {1'b0, r_a[W-1:1]};
                w_step_c = r_a[0];
            end
            OP_SHL: begin
                {w_step_c, w_step_a} = {r_a, 1'b0};
            end
`ifdef ALU_SEQ_ROTATE_EN
            OP_ROR: begin
                {w_step_a, w_step_c} = {r_c, r_a};
            end
            OP_ROL: begin
                {w_step_c, w_step_a} = {r_a, r_c};
            end
`endif
            default: begin
                w_step_a = r_a;
                w_step_c = r_c;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_go_shift ? S_SHIFT : S_FIN;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Visible results change only on the edge that
    // enters FIN; intermediate shift values stay in r_a/r_c.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_sc      <= 1'b0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            // The illegal flag lives only for the FIN cycle.
            r_illegal <= 1'b0;
            if (w_accept) begin
                r_op  <= i_op;
                r_a   <= i_inputa;
                r_c   <= i_sc_in;
                r_cnt <= w_n;
                if (!w_go_shift) begin
                    r_out     <= w_res;
                    r_sc      <= w_c;
                    r_zero    <= (w_res == '0);
                    r_illegal <= w_ill;
                end
            end else if (r_state == S_SHIFT) begin
                r_a   <= w_step_a;
                r_c   <= w_step_c;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_out  <= w_step_a;
                    r_sc   <= w_step_c;
                    r_zero <= (w_step_a == '0);
                end
            end
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_FIN);
    assign o_out     = r_out;
    assign o_sc_out  = r_sc;
    assign o_zero    = r_zero;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (W = 8).
// Directed cases from the operation table, then random ops against a reference model.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [3:0]   i_op;
    logic [W-1:0] i_inputa;
    logic [W-1:0] i_inputb;
    logic         i_sc_in;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_out;
    logic         o_sc_out;
    logic         o_zero;
    logic         o_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           lat;
        logic [W-1:0] out;
        logic         sc;
        logic         ill;
    } exp_t;

    alu_seq #(.W(W)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_inputa  (i_inputa),
        .i_inputb  (i_inputb),
        .i_sc_in   (i_sc_in),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_out     (o_out),
        .o_sc_out  (o_sc_out),
        .o_zero    (o_zero),
        .o_illegal (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [W-1:0] out,
                                input logic sc, input logic ill);
        exp_t e;
        e.lat = lat;
        e.out = out;
        e.sc  = sc;
        e.ill = ill;
        return e;
    endfunction

    // Reference model: plain arithmetic on wide integers.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic sci);
        exp_t e;
        longint unsigned va, vb, mask, r, v, m1;
        int n, k;
        va    = 64'(a);
        vb    = 64'(b);
        mask  = (64'd1 << W) - 1;
        m1    = (64'd1 << (W + 1)) - 1;
        r     = 0;
        n     = int'(vb % (64'd1 << CW));
        e.lat = 1;
        e.sc  = 1'b0;
        e.ill = 1'b0;
        case (int'(op))
            0: r = va;
            1: r = vb;
            2: r = va ^ vb;
            3: r = va | vb;
            4: r = va & vb;
            5: begin
                r    = va + vb + 64'(sci);
                e.sc = r[W];
            end
            6: begin
                r    = (va - vb) & mask;
                e.sc = (va >= vb);
            end
            7: begin
                if (n > W + 1) n = W + 1;
                r     = va >> n;
                e.sc  = (n == 0) ? 1'b0 : ((va >> (n - 1)) & 1) != 0;
                e.lat = (n == 0) ? 1 : n + 1;
            end
            8: begin
                if (n > W + 1) n = W + 1;
                r     = (va << n) & mask;
                e.sc  = (n == 0) ? 1'b0 : (((va << (n - 1)) >> (W - 1)) & 1) != 0;
                e.lat = (n == 0) ? 1 : n + 1;
            end
`ifdef ALU_SEQ_ROTATE_EN
            9, 10: begin
                k = n % (W + 1);
                v = (64'(sci) << W) | va;
                if (op == 4'd9)
                    v = ((v >> k) | (v << (W + 1 - k))) & m1;
                else
                    v = ((v << k) | (v >> (W + 1 - k))) & m1;
                r     = v & mask;
                e.sc  = v[W];
                e.lat = (n == 0) ? 1 : n + 1;
            end
`endif
            default: begin
                e.ill = 1'b1;
                r     = 0;
            end
        endcase
        e.out = r[W-1:0];
        return e;
    endfunction

    // Issue one op, scramble inputs while busy, optionally raise a stray
    // START in cycle 'spur' (counted from the acceptance edge), then check.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sci, input exp_t e, input int spur);
        int lat;
        int busy_bad;
        int extra;
        i_op     = op;
        i_inputa = a;
        i_inputb = b;
        i_sc_in  = sci;
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start  = 1'b0;
        i_op     = 4'($urandom);
        i_inputa = W'($urandom);
        i_inputb = W'($urandom);
        i_sc_in  = 1'($urandom);
        lat      = 1;
        busy_bad = 0;
        while (o_done !== 1'b1 && lat < 40) begin
            if (o_busy !== 1'b1) busy_bad++;
            i_start = (lat == spur);
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, ":latency"}, 64'(lat), 64'(e.lat));
        check({tag, ":busy_during"}, 64'(busy_bad), 64'd0);
        check({tag, ":busy_fin"}, 64'(o_busy), 64'd1);
        check({tag, ":out"}, 64'(o_out), 64'(e.out));
        check({tag, ":sc"}, 64'(o_sc_out), 64'(e.sc));
        check({tag, ":zero"}, 64'(o_zero), 64'(e.out == '0));
        check({tag, ":illegal"}, 64'(o_illegal), 64'(e.ill));
        i_start = (lat == spur);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check({tag, ":idle_busy"}, 64'(o_busy), 64'd0);
        extra = 0;
        repeat (2) begin
            if (o_done !== 1'b0) extra++;
            @(posedge i_clk); #1;
        end
        check({tag, ":no_extra_done"}, 64'(extra), 64'd0);
        check({tag, ":out_hold"}, 64'(o_out), 64'(e.out));
    endtask

    initial begin
        int extra;
        exp_t e;
        logic [3:0] op;
        logic [W-1:0] a, b;
        logic sci;
        int spur;

        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_op     = '0;
        i_inputa = '0;
        i_inputb = '0;
        i_sc_in  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        check("rst:busy", 64'(o_busy), 64'd0);
        check("rst:done", 64'(o_done), 64'd0);
        check("rst:out", 64'(o_out), 64'd0);
        check("rst:sc", 64'(o_sc_out), 64'd0);
        check("rst:zero", 64'(o_zero), 64'd1);
        check("rst:illegal", 64'(o_illegal), 64'd0);

        run_op("add", 4'd5, 8'hF0, 8'h20, 1'b1, mk(1, 8'h11, 1'b1, 1'b0), 0);
        run_op("shr3", 4'd7, 8'hB3, 8'h03, 1'b0, mk(4, 8'h16, 1'b0, 1'b0), 2);
        run_op("shl8", 4'd8, 8'hB3, 8'h08, 1'b0, mk(9, 8'h00, 1'b1, 1'b0), 0);
        run_op("shl9", 4'd8, 8'hB3, 8'h09, 1'b0, mk(10, 8'h00, 1'b0, 1'b0), 0);
        run_op("shl0", 4'd8, 8'hB3, 8'h00, 1'b1, mk(1, 8'hB3, 1'b0, 1'b0), 0);
        run_op("shr_sat", 4'd7, 8'hB3, 8'h0F, 1'b0, mk(10, 8'h00, 1'b0, 1'b0), 0);
        run_op("sub_eq", 4'd6, 8'h05, 8'h05, 1'b0, mk(1, 8'h00, 1'b1, 1'b0), 0);
        run_op("sub_lt", 4'd6, 8'h03, 8'h05, 1'b1, mk(1, 8'hFE, 1'b0, 1'b0), 0);
        run_op("mov_finstart", 4'd0, 8'h5A, 8'h00, 1'b0, mk(1, 8'h5A, 1'b0, 1'b0), 1);
`ifdef ALU_SEQ_ROTATE_EN
        run_op("rol1", 4'd10, 8'h80, 8'h01, 1'b0, mk(2, 8'h00, 1'b1, 1'b0), 0);
`else
        run_op("rol1", 4'd10, 8'h80, 8'h01, 1'b0, mk(1, 8'h00, 1'b0, 1'b1), 0);
`endif
        run_op("op15", 4'd15, 8'hFF, 8'h01, 1'b1, mk(1, 8'h00, 1'b0, 1'b1), 0);

        // Reset in the middle of a shift aborts it.
        run_op("pre_rst", 4'd1, 8'h00, 8'h77, 1'b0, mk(1, 8'h77, 1'b0, 1'b0), 0);
        i_op     = 4'd7;
        i_inputa = 8'hB3;
        i_inputb = 8'h05;
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("abort:busy", 64'(o_busy), 64'd0);
        check("abort:done", 64'(o_done), 64'd0);
        check("abort:out", 64'(o_out), 64'd0);
        check("abort:zero", 64'(o_zero), 64'd1);
        extra = 0;
        repeat (8) begin
            @(posedge i_clk); #1;
            if (o_done !== 1'b0) extra++;
        end
        check("abort:no_done", 64'(extra), 64'd0);
        run_op("post_rst_add", 4'd5, 8'h01, 8'h02, 1'b0, mk(1, 8'h03, 1'b0, 1'b0), 0);

        // Reset and START together: START is dropped.
        i_op     = 4'd1;
        i_inputb = 8'h42;
        i_start  = 1'b1;
        i_reset  = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_reset = 1'b0;
        check("rst_start:busy", 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
        check("rst_start:done", 64'(o_done), 64'd0);
        check("rst_start:out", 64'(o_out), 64'd0);

        for (int i = 0; i < 200; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = W'($urandom);
            b    = W'($urandom);
            sci  = 1'($urandom);
            spur = $urandom_range(0, 12);
            e    = model(op, a, b, sci);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, sci, e, spur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 8-bit datapath ALU. It executes one operation per START/DONE handshake. Logic, move and add/sub complete in one cycle; shifts and rotates iterate one bit per cycle, with the last bit shifted out returned as carry. It sits between the register file read ports and the writeback mux, and the control FSM stalls on BUSY.

## Interface
- W, 8: datapath width in bits, ≥ 4.
- CW, $clog2(W)+1: width of the shift-amount field taken from INPUTB[CW-1:0]. Derived; do not override.
- CLK  input  1  clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- OP  input  4  opcode, captured with START.
- INPUTA  input  W  operand A, captured with START.
- INPUTB  input  W  operand B or shift amount, captured with START.
- SC_IN  input  1  carry in, captured with START.
- BUSY  output  1  high whenever state ≠ IDLE.
- DONE  output  1  one-cycle pulse; results valid in this cycle.
- OUT  output  W  registered result; holds until the next DONE.
- SC_OUT  output  1  registered carry or shift-out bit.
- ZERO  output  1  registered (OUT == 0).
- ILLEGAL  output  1  high together with DONE when OP is unsupported.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states are IDLE, SHIFT and FIN.
  - IDLE to FIN when START is high and the op is non-shift, or is a shift with n = 0.
  - IDLE to SHIFT when START is high and the op is a shift with n ≥ 1.
  - SHIFT to FIN after n iterations.
  - FIN to IDLE unconditionally.
- Opcodes:
  - 0 MOV: OUT = A.
  - 1 MOVR: OUT = B.
  - 2 XOR, 3 OR, 4 AND: bitwise; SC_OUT = 0.
  - 5 ADD: {SC_OUT, OUT} = A + B + SC_IN, computed at W+1 bits.
  - 6 SUB: {SC_OUT, OUT} = A + ~B + 1. SC_OUT = 1 means no borrow (A ≥ B unsigned). SC_IN is ignored.
  - 7 SHR, 8 SHL: logical shift, zero fill.
    - n = min(INPUTB[CW-1:0], W+1); perform n single-bit shifts.
    - SC_OUT = the bit shifted out on the last iteration.
    - n = 0 gives OUT = A, SC_OUT = 0.
    - n = W gives OUT = 0, SC_OUT = A[0] (SHL) or A[W-1] (SHR).
    - n = W+1 gives OUT = 0, SC_OUT = 0.
  - 9 ROR, 10 ROL: rotate through carry on the (W+1)-bit register {SC_IN, A}, n = INPUTB[CW-1:0] iterations, no saturation. Only present when the macro below is defined.
  - 11–15, and 9–10 without the macro: illegal. Result: OUT = 0, SC_OUT = 0, ZERO = 1, ILLEGAL = 1 in the FIN cycle.
- ZERO is computed from the final result and registered alongside OUT.
- START while BUSY, including the FIN cycle, is ignored: no queueing and no effect on the running op.
- Operands are captured on acceptance. Input changes during BUSY have no effect.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, OUT 0, SC_OUT 0, ZERO 1, ILLEGAL 0. The iteration counter and operand registers are cleared.
- Latency, with START accepted at edge t:
  - Non-shift ops, and shifts with n = 0: DONE at cycle t+1.
  - Shifts with n ≥ 1: SHIFT occupies cycles t+1..t+n, and DONE is at t+n+1.
- Maximum throughput: one op per 2 cycles.
- DONE is high only in FIN. BUSY is high in SHIFT and FIN.
- OUT, SC_OUT and ZERO update only at the FIN-entry edge. Intermediate shift values are internal and never visible on OUT.
- Reset asserted in any state aborts the op on that edge. No DONE is produced and outputs take their reset values.
- Reset and START in the same cycle: Reset wins and START is dropped.

## Configuration
- ALU_SEQ_ROTATE_EN, defined: opcodes 9 (ROR) and 10 (ROL) are implemented as specified above.
- ALU_SEQ_ROTATE_EN, undefined: opcodes 9 and 10 decode as illegal. Their timing is the same as any illegal op (DONE at t+1, ILLEGAL = 1), and no rotate logic is synthesised.

## Test plan
- ADD, W=8, A=0xF0, B=0x20, SC_IN=1 -> DONE at t+1, OUT=0x11, SC_OUT=1, ZERO=0, ILLEGAL=0.
- SHR, A=0xB3, B=3 -> BUSY for cycles t+1..t+4, DONE at t+4, OUT=0x16, SC_OUT=0. A second START raised at t+2 is ignored (no extra DONE).
- SHL, A=0xB3:
  - B=8 -> DONE at t+9, OUT=0x00, SC_OUT=1, ZERO=1.
  - B=9 -> DONE at t+10, OUT=0x00, SC_OUT=0.
  - B=0 -> DONE at t+1, OUT=0xB3, SC_OUT=0.
- SUB:
  - A=0x05, B=0x05 -> OUT=0x00, SC_OUT=1, ZERO=1.
  - A=0x03, B=0x05 -> OUT=0xFE, SC_OUT=0.
- Reset asserted at t+2 of SHR with B=5 -> no DONE, BUSY=0, OUT=0, ZERO=1 from the next cycle. A new ADD is then accepted normally.
- OP=10, A=0x80, SC_IN=0, B=1:
  - With ALU_SEQ_ROTATE_EN -> DONE at t+2, OUT=0x00, SC_OUT=1.
  - Without it -> DONE at t+1, ILLEGAL=1, OUT=0.
  - OP=15 -> ILLEGAL=1 in both builds.
